mux8_scan_ctrl: RTL and testbench
=================================

# mux8_scan_ctrl

Sequential scan controller that sits around the 8:1 mux stage. It drives the 3-bit select into the mux and samples the mux output Y once per channel, giving each channel a programmable settle time. After all eight channels are captured, it presents them as an 8-bit word on a valid/ready handshake. It turns the combinational mux into a one-shot parallel sampler for downstream logic.

## Interface
- SETTLE_CYCLES, default 1: cycles `sel` is held before `Y` is sampled; legal range 1..15.
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  scan request; sampled only in IDLE.
- sel  output  3  channel select driven to the mux `sel` port.
- Y  input  1  mux output for the currently selected channel.
- data  output  8  captured word; `data[i]` = Y sampled while `sel` = i.
- valid  output  1  `data` holds a completed scan not yet accepted.
- ready  input  1  consumer accepts `data` when `valid` && `ready`.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, SETTLE, SAMPLE, HOLD.
- IDLE:
  - `sel` = 0, `busy` = 0, `valid` = 0.
  - `start` = 1 → SETTLE; settle counter cleared; `sel` stays 0.
- SETTLE:
  - Counter increments each cycle.
  - When the counter reaches SETTLE_CYCLES-1 → SAMPLE.
- SAMPLE (one cycle):
  - On the exit edge, Y is written into shadow bit `sel`.
  - If `sel` != 7: `sel` increments, counter clears, → SETTLE.
  - If `sel` = 7: shadow register (including bit 7 captured this edge) copied to `data`, `valid` set, → HOLD.
- HOLD:
  - `sel` stays 7; `valid` stays 1; `data` stays stable.
  - `valid` && `ready` → IDLE; `valid` drops and `sel` returns to 0 on that edge.
- `data` changes only on the edge that raises `valid`. It keeps the last word through IDLE and the next scan.
- `start` is ignored outside IDLE; it is not queued.
- `ready` is ignored outside HOLD.
- `sel` changes only on SAMPLE exit edges and on HOLD→IDLE. It never glitches mid-settle.
- The counter is 4 bits; SETTLE_CYCLES outside 1..15 is illegal (elaboration-time assertion).

## Timing
- Reset values: `sel` = 0, `data` = 8'h00, `valid` = 0, `busy` = 0, state IDLE, counter 0, shadow 8'h00.
- Reset asserted mid-scan or in HOLD clears everything immediately, without waiting for a clock edge. No partial word is ever presented.
- Per-channel time is SETTLE_CYCLES+1 cycles.
- With `start` sampled at edge E0:
  - Channel i is captured at E0 + (i+1)(SETTLE_CYCLES+1).
  - `valid` rises at E0 + 8(SETTLE_CYCLES+1); 16 cycles at default.
- `busy` rises at E0 and falls on the accepting edge.
- `ready` already high when `valid` rises: accepted on the next edge, so `valid` is high exactly one cycle.
- `start` high on the accepting edge is not seen (state is HOLD). A new scan starts at the earliest one edge later, from IDLE.
- `ready` is not combinationally coupled to any output.

## Configuration
- MUX8_SCAN_PARITY_EN:
  - Defined: adds output port `parity` (1 bit) = XOR of `data`. It is registered and updated on the same edge as `data`; reset value 0.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset then idle: hold reset_n = 0, then release with `start` = 0 for 20 cycles → `sel` = 0, `data` = 00, `valid` = 0, `busy` = 0 throughout.
- Basic scan:
  - Stimulus: SETTLE_CYCLES = 1, Y driven by a model mux over pattern 8'hA5, `ready` = 1, `start` pulsed at E0.
  - Response: `sel` steps 0..7, each value held 2 cycles; `valid` high only at E0+16 for one cycle; `data` = A5; parity = 0 when enabled.
- Backpressure:
  - Stimulus: pattern 8'h3C, `ready` = 0 for 10 cycles after `valid`, then `ready` = 1.
  - Response: `valid` and `data` = 3C stable 11 cycles; `busy` = 1 until accept; `start` pulses during HOLD are ignored.
- Settle honoured:
  - Stimulus: SETTLE_CYCLES = 4; the model mux drives Y = ~pattern on the first cycle after each `sel` change.
  - Response: `data` equals the pattern (8'h96), not its inverse; `valid` rises at E0+40.
- Reset mid-scan:
  - Stimulus: assert reset_n = 0 between clock edges while `sel` = 4, release, then scan pattern 8'hFF.
  - Response: `sel`, `busy` and `valid` drop immediately and `data` = 00; the next scan yields FF (parity 0 when enabled).
- Back-to-back:
  - Stimulus: `start` held high continuously with `ready` = 1, patterns 8'h01 then 8'h80.
  - Response: two words, 01 then 80; the second scan's E0 falls one cycle after the first accept.

Source files
------------

// File: rtl/mux8_scan_ctrl.sv
// Scan controller for an 8:1 mux: steps sel 0..7, samples Y after a settle time, then
// presents the captured byte on valid/ready. Define MUX8_SCAN_PARITY_EN to add a parity output.
module mux8_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic [2:0] sel,
    input  logic       Y,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy
`ifdef MUX8_SCAN_PARITY_EN
    ,
    output logic       parity
`endif
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $fatal(1, "SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StHold} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [2:0]  sel_q;
    logic [7:0]  shadow_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        busy_q;
    logic        parity_q;

    // Channel 7 is written straight into data alongside the older shadow bits.
    logic [7:0]  word;
    assign word = {Y, shadow_q[6:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            sel_q    <= 3'd0;
            shadow_q <= 8'h00;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StSettle;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b1;
                    end
                end
                StSettle: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == SettleLast) begin
                        state_q <= StSample;
                    end
                end
                StSample: begin
                    shadow_q[sel_q] <= Y;
                    if (sel_q != 3'd7) begin
                        sel_q   <= sel_q + 3'd1;
                        cnt_q   <= 4'd0;
                        state_q <= StSettle;
                    end else begin
                        data_q   <= word;
                        parity_q <= ^word;
                        valid_q  <= 1'b1;
                        state_q  <= StHold;
                    end
                end
                StHold: begin
                    if (ready) begin
                        valid_q <= 1'b0;
                        sel_q   <= 3'd0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sel   = sel_q;
    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = busy_q;

`ifdef MUX8_SCAN_PARITY_EN
    assign parity = parity_q;
`else
    logic unused_parity;
    assign unused_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Directed bench for mux8_scan_ctrl: one instance at SETTLE_CYCLES=1, one at 4 driven by a
// model mux that shows the inverted value on the first cycle after each sel change.
module tb_mux8_scan_ctrl;

    logic       clk;
    logic       reset_n;
    logic       start1, ready1, y1, valid1, busy1;
    logic [2:0] sel1;
    logic [7:0] data1, pat1;
    logic       start4, ready4, y4, valid4, busy4;
    logic [2:0] sel4, prev_sel4;
    logic [7:0] data4, pat4;
`ifdef MUX8_SCAN_PARITY_EN
    logic       parity1, parity4;
`endif

    int total;
    int bad;
    int n;

    mux8_scan_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start1),
        .sel     (sel1),
        .Y       (y1),
        .data    (data1),
        .valid   (valid1),
        .ready   (ready1),
        .busy    (busy1)
`ifdef MUX8_SCAN_PARITY_EN
        ,
        .parity  (parity1)
`endif
    );

    mux8_scan_ctrl #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start4),
        .sel     (sel4),
        .Y       (y4),
        .data    (data4),
        .valid   (valid4),
        .ready   (ready4),
        .busy    (busy4)
`ifdef MUX8_SCAN_PARITY_EN
        ,
        .parity  (parity4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) prev_sel4 <= sel4;

    assign y1 = pat1[sel1];
    assign y4 = (sel4 != prev_sel4) ? ~pat4[sel4] : pat4[sel4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        start1 = 1'b0; ready1 = 1'b0; pat1 = 8'h00;
        start4 = 1'b0; ready4 = 1'b0; pat4 = 8'h00;
        #22 reset_n = 1'b1;

        // Reset then idle
        for (int k = 0; k < 20; k++) begin
            step();
            chk("idle_all", {sel1, data1, valid1, busy1}, 32'd0);
        end

        // Basic scan, A5
        pat1 = 8'hA5; ready1 = 1'b1; start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("basic_sel", sel1, k / 2);
            chk("basic_valid_low", valid1, 0);
            chk("basic_busy", busy1, 1);
            step();
        end
        chk("basic_valid", valid1, 1);
        chk("basic_data", data1, 8'hA5);
        chk("basic_sel_hold", sel1, 7);
`ifdef MUX8_SCAN_PARITY_EN
        chk("basic_parity", parity1, 0);
`endif
        step();
        chk("basic_accept_valid", valid1, 0);
        chk("basic_accept_busy", busy1, 0);
        chk("basic_accept_sel", sel1, 0);
        chk("basic_data_kept", data1, 8'hA5);

        // Backpressure, 3C
        pat1 = 8'h3C; ready1 = 1'b0; start1 = 1'b1;
        step();
        start1 = 1'b0;
        repeat (16) step();
        for (int k = 0; k < 11; k++) begin
            chk("bp_valid", valid1, 1);
            chk("bp_data", data1, 8'h3C);
            chk("bp_busy", busy1, 1);
            chk("bp_sel", sel1, 7);
            start1 = (k == 3);
            if (k == 10) ready1 = 1'b1;
            step();
        end
        chk("bp_accept_valid", valid1, 0);
        chk("bp_accept_busy", busy1, 0);
        chk("bp_data_kept", data1, 8'h3C);
        step();
        chk("bp_start_not_queued", busy1, 0);

        // Settle honoured, SETTLE_CYCLES=4, 96
        pat4 = 8'h96; ready4 = 1'b1; start4 = 1'b1;
        step();
        start4 = 1'b0;
        repeat (39) step();
        chk("settle_valid_early", valid4, 0);
        step();
        chk("settle_valid", valid4, 1);
        chk("settle_data", data4, 8'h96);
        chk("settle_sel", sel4, 7);
`ifdef MUX8_SCAN_PARITY_EN
        chk("settle_parity", parity4, 0);
`endif
        step();
        chk("settle_accept", valid4, 0);

        // Reset mid-scan, then FF
        pat1 = 8'h5A; ready1 = 1'b1; start1 = 1'b1;
        step();
        start1 = 1'b0;
        repeat (8) step();
        chk("mid_sel", sel1, 4);
        chk("mid_busy", busy1, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_sel", sel1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_valid", valid1, 0);
        chk("rst_data", data1, 8'h00);
        #2 reset_n = 1'b1;
        pat1 = 8'hFF; start1 = 1'b1;
        step();
        start1 = 1'b0;
        repeat (16) step();
        chk("ff_valid", valid1, 1);
        chk("ff_data", data1, 8'hFF);
`ifdef MUX8_SCAN_PARITY_EN
        chk("ff_parity", parity1, 0);
`endif
        step();
        chk("ff_accept", valid1, 0);

        // Back-to-back, 01 then 80
        pat1 = 8'h01; ready1 = 1'b1; start1 = 1'b1;
        n = 0;
        while (!valid1 && n < 40) begin
            step();
            n++;
        end
        chk("b2b_first_valid", valid1, 1);
        chk("b2b_first_latency", n, 17);
        chk("b2b_first_data", data1, 8'h01);
        pat1 = 8'h80;
        step();
        chk("b2b_accept_busy", busy1, 0);
        chk("b2b_accept_valid", valid1, 0);
        step();
        chk("b2b_restart_busy", busy1, 1);
        repeat (15) step();
        chk("b2b_second_early", valid1, 0);
        step();
        chk("b2b_second_valid", valid1, 1);
        chk("b2b_second_data", data1, 8'h80);
        start1 = 1'b0;
        step();
        chk("b2b_second_accept", valid1, 0);
        chk("b2b_end_busy", busy1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
